// File: rtl/sm4_pkg.sv
// Shared SM4 constants, enums and the CK round-constant generator for the iterative SM4 engine.
package sm4_pkg;

  localparam int SM4_ROUNDS = 32;

  localparam logic [31:0] FK [4] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

  typedef enum logic [1:0] {
    OP_KEY = 2'b00,
    OP_ENC = 2'b01,
    OP_DEC = 2'b10,
    OP_RSV = 2'b11
  } sm4_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ROUND = 2'b01,
    ST_DONE  = 2'b10
  } sm4_seq_state_e;

  // CK[i] byte j (byte 0 = MSB) is ((4i+j)*7) mod 256; computed instead of stored.
  function automatic logic [31:0] sm4_ck(logic [4:0] i);
    logic [7:0]  base;
    logic [31:0] ck;
    base = {1'b0, i, 2'b00};
    ck   = '0;
    for (int j = 0; j < 4; j++) begin
      ck[31-8*j -: 8] = (base + 8'(j)) * 8'd7;
    end
    return ck;
  endfunction

endpackage

// File: rtl/sm4lt.sv
// SM4 mixer-substitution transform: S-box layer followed by L (mode_i=1, data) or L' (mode_i=0, key).
module sm4lt (
  input  logic [31:0] x_i,
  input  logic        mode_i,
  output logic [31:0] y_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  function automatic logic [31:0] rotl(logic [31:0] v, int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  logic [31:0] b;

  always_comb begin
    b = {SBOX[x_i[31:24]], SBOX[x_i[23:16]], SBOX[x_i[15:8]], SBOX[x_i[7:0]]};
    if (mode_i) y_o = b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
    else        y_o = b ^ rotl(b, 13) ^ rotl(b, 23);
  end

endmodule

// File: rtl/sm4_round_seq.sv
// Iterative SM4 engine: key expansion into a 32-word round-key store, then block ENC/DEC, one round
// per clock through a shared sm4lt. Define SM4_SEQ_DEC_EN to enable the DEC op (else it is rejected).
module sm4_round_seq
  import sm4_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [1:0]   req_op_i,
  input  logic [127:0] req_data_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [127:0] rsp_data_o,
  output logic         rsp_err_o,
  output logic         key_valid_o,
  output logic         busy_o
);

  sm4_seq_state_e state_q;
  sm4_op_e        op_q;
  logic [4:0]     rnd_cnt_q;
  logic [31:0]    x_q  [4];
  logic [31:0]    rk_q [SM4_ROUNDS];
  logic           key_valid_q, req_ready_q, rsp_valid_q, rsp_err_q, busy_q;

  logic [31:0] rk_sel, round_key, t_in, t_out, x4;
  logic        req_err;

  always_comb begin
    rk_sel = rk_q[rnd_cnt_q];
`ifdef SM4_SEQ_DEC_EN
    // 31 - rnd_cnt for a 5-bit counter is its bitwise complement.
    if (op_q == OP_DEC) rk_sel = rk_q[~rnd_cnt_q];
`endif
    round_key = (op_q == OP_KEY) ? sm4_ck(rnd_cnt_q) : rk_sel;
    t_in      = x_q[1] ^ x_q[2] ^ x_q[3] ^ round_key;
    x4        = x_q[0] ^ t_out;
  end

  sm4lt u_lt (
    .x_i    (t_in),
    .mode_i (op_q != OP_KEY),
    .y_o    (t_out)
  );

  always_comb begin
    req_err = 1'b1;
    case (sm4_op_e'(req_op_i))
      OP_KEY: req_err = 1'b0;
      OP_ENC: req_err = !key_valid_q;
`ifdef SM4_SEQ_DEC_EN
      OP_DEC: req_err = !key_valid_q;
`endif
      default: req_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_KEY;
      rnd_cnt_q   <= '0;
      for (int i = 0; i < 4; i++) x_q[i] <= '0;
      for (int i = 0; i < SM4_ROUNDS; i++) rk_q[i] <= '0;
      key_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            op_q        <= sm4_op_e'(req_op_i);
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (req_err) begin
              // Rejected ops skip the rounds; zeroed X makes the response data zero.
              state_q     <= ST_DONE;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              for (int i = 0; i < 4; i++) x_q[i] <= '0;
            end else begin
              state_q   <= ST_ROUND;
              rsp_err_q <= 1'b0;
              if (sm4_op_e'(req_op_i) == OP_KEY) begin
                key_valid_q <= 1'b0;
                for (int i = 0; i < 4; i++) x_q[i] <= req_data_i[127-32*i -: 32] ^ FK[i];
              end else begin
                for (int i = 0; i < 4; i++) x_q[i] <= req_data_i[127-32*i -: 32];
              end
            end
          end
        end
        ST_ROUND: begin
          x_q[0] <= x_q[1];
          x_q[1] <= x_q[2];
          x_q[2] <= x_q[3];
          x_q[3] <= x4;
          if (op_q == OP_KEY) rk_q[rnd_cnt_q] <= x4;
          rnd_cnt_q <= rnd_cnt_q + 5'd1;
          if (rnd_cnt_q == 5'(SM4_ROUNDS - 1)) begin
            state_q     <= ST_DONE;
            rsp_valid_q <= 1'b1;
            if (op_q == OP_KEY) key_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (rsp_ready_i) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // After KEY the X registers hold rk28..rk31, returned in ascending order.
  assign rsp_data_o  = (op_q == OP_KEY) ? {x_q[0], x_q[1], x_q[2], x_q[3]}
                                        : {x_q[3], x_q[2], x_q[1], x_q[0]};
  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign key_valid_o = key_valid_q;
  assign busy_o      = busy_q;

endmodule
